// File: rtl/hada_sign_compose.sv
// Sign/magnitude to two's-complement composer, two-stage valid/ready pipeline.
// Define HADA_SIGN_COMPOSE_SAT_EN to saturate overflowed results instead of wrapping.
module hada_sign_compose #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mag,
    input  logic [1:0]       in_sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic [15:0]      ovf_count
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid;
    logic [WIDTH-1:0] s1_mag;
    logic [1:0]       s1_sgn;
    logic             s1_adv;
    logic [WIDTH-1:0] neg_mag;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf;

    // S2 can take a new beat when empty or when its beat leaves this cycle.
    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    // Compose the signed result and overflow flag from the S1 beat.
    always_comb begin
        res_data = '0;
        res_ovf  = 1'b0;
        neg_mag  = '0 - s1_mag;
        case (s1_sgn)
            2'b01: begin
                res_ovf = s1_mag[WIDTH-1];
`ifdef HADA_SIGN_COMPOSE_SAT_EN
                res_data = res_ovf ? MAX_POS : s1_mag;
`else
                res_data = s1_mag;
`endif
            end
            2'b11: begin
                // Only magnitudes strictly above 2^(W-1) fall out of range.
                res_ovf = s1_mag[WIDTH-1] && (|s1_mag[WIDTH-2:0]);
`ifdef HADA_SIGN_COMPOSE_SAT_EN
                res_data = res_ovf ? MIN_NEG : neg_mag;
`else
                res_data = neg_mag;
`endif
            end
            2'b10: begin
                res_ovf  = 1'b1;
                res_data = '0;
            end
            default: begin
                res_ovf  = 1'b0;
                res_data = '0;
            end
        endcase
    end

    // S1: capture the input beat whenever the stage is free to move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mag   <= '0;
            s1_sgn   <= 2'b00;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mag <= in_mag;
                s1_sgn <= in_sgn;
            end
        end
    end

    // S2: register the composed result; held while stalled downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res_data;
                out_ovf  <= res_ovf;
            end
        end
    end

    // Count delivered overflow beats, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= 16'h0000;
        end else if (out_valid && out_ready && out_ovf
                     && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hada_sign_compose.sv
// Scoreboard bench for hada_sign_compose at WIDTH=8.
// Expected results are hand-computed; the SAT_EN macro selects the saturating column.
module tb_hada_sign_compose;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_mag;
    logic [1:0]   in_sgn;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic [15:0]  ovf_count;

    int checks = 0;
    int failures = 0;
    int n_ovf_sent = 0;

    exp_t sbq[$];
    logic [15:0] exp_cnt = 16'h0;
    bit stalled = 1'b0;
    logic [W-1:0] hold_d;
    logic hold_o;

    hada_sign_compose #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mag(in_mag),
        .in_sgn(in_sgn),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ovf(out_ovf),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Push the expectation, present the beat and hold it until accepted.
    task automatic send(input logic [W-1:0] m, input logic [1:0] s,
                        input logic [W-1:0] d, input logic o,
                        output int tries);
        logic acc;
        exp_t e;
        e.d = d;
        e.o = o;
        sbq.push_back(e);
        if (o) n_ovf_sent++;
        in_valid = 1'b1;
        in_mag = m;
        in_sgn = s;
        tries = 0;
        do begin
            #2;
            acc = in_ready;
            tries++;
            @(negedge clk);
        end while (!acc && tries < 50);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=%0d required=accept", tries);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pop and compare on every delivered beat, check stalls and counter.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            stalled = 1'b0;
            exp_cnt = 16'h0;
        end else begin
            chk("ovf_count", 64'(ovf_count), 64'(exp_cnt));
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(hold_d));
                chk("stall_ovf", 64'(out_ovf), 64'(hold_o));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none",
                             out_data);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_ovf", 64'(out_ovf), 64'(e.o));
                    if (e.o && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end
            end
            stalled = out_valid && !out_ready;
            hold_d = out_data;
            hold_o = out_ovf;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] vm[11];
    logic [1:0] vs[11];
    logic [7:0] vwrap[11];
    logic [7:0] vsat[11];
    logic       vo[11];

    initial begin
        int t;
        time t0;
        vm[0] = 8'd5;   vs[0] = 2'b11; vwrap[0] = 8'hFB; vsat[0] = 8'hFB; vo[0] = 0;
        vm[1] = 8'd128; vs[1] = 2'b01; vwrap[1] = 8'h80; vsat[1] = 8'h7F; vo[1] = 1;
        vm[2] = 8'd128; vs[2] = 2'b11; vwrap[2] = 8'h80; vsat[2] = 8'h80; vo[2] = 0;
        vm[3] = 8'd0;   vs[3] = 2'b11; vwrap[3] = 8'h00; vsat[3] = 8'h00; vo[3] = 0;
        vm[4] = 8'd77;  vs[4] = 2'b00; vwrap[4] = 8'h00; vsat[4] = 8'h00; vo[4] = 0;
        vm[5] = 8'd127; vs[5] = 2'b01; vwrap[5] = 8'h7F; vsat[5] = 8'h7F; vo[5] = 0;
        vm[6] = 8'd129; vs[6] = 2'b11; vwrap[6] = 8'h7F; vsat[6] = 8'h80; vo[6] = 1;
        vm[7] = 8'd255; vs[7] = 2'b01; vwrap[7] = 8'hFF; vsat[7] = 8'h7F; vo[7] = 1;
        vm[8] = 8'd9;   vs[8] = 2'b10; vwrap[8] = 8'h00; vsat[8] = 8'h00; vo[8] = 1;
        vm[9] = 8'd255; vs[9] = 2'b10; vwrap[9] = 8'h00; vsat[9] = 8'h00; vo[9] = 1;
        vm[10] = 8'd1;  vs[10] = 2'b01; vwrap[10] = 8'h01; vsat[10] = 8'h01; vo[10] = 0;

        rst = 1'b1;
        in_valid = 1'b0;
        in_mag = '0;
        in_sgn = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_ovf_count", 64'(ovf_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // First edge after reset accepts; latency check on 5/minus.
        send(8'd5, 2'b11, 8'hFB, 1'b0, t);
        chk("first_accept_tries", 64'(t), 64'd1);
        #2;
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        @(negedge clk);
        #2;
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_out_data", 64'(out_data), 64'hFB);
        @(negedge clk);
        idle(2);

        // Directed table, back-to-back.
        for (int i = 0; i < 11; i++) begin
`ifdef HADA_SIGN_COMPOSE_SAT_EN
            send(vm[i], vs[i], vsat[i], vo[i], t);
`else
            send(vm[i], vs[i], vwrap[i], vo[i], t);
`endif
        end
        idle(4);

        // 200/minus overflows; counter should step by one.
`ifdef HADA_SIGN_COMPOSE_SAT_EN
        send(8'd200, 2'b11, 8'h80, 1'b1, t);
`else
        send(8'd200, 2'b11, 8'h38, 1'b1, t);
`endif
        idle(4);
        chk("ovf_count_200", 64'(ovf_count), 64'(n_ovf_sent));

        // Four beats with out_ready low for three cycles.
        out_ready = 1'b0;
        fork
            begin
                send(8'd1, 2'b01, 8'h01, 1'b0, t);
                send(8'd2, 2'b11, 8'hFE, 1'b0, t);
                send(8'd3, 2'b01, 8'h03, 1'b0, t);
                send(8'd4, 2'b10, 8'h00, 1'b1, t);
            end
            begin
                repeat (2) @(negedge clk);
                #2;
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle(5);

        // Reset with two beats in flight: both must vanish.
        out_ready = 1'b0;
        send(8'd9, 2'b10, 8'h00, 1'b1, t);
        send(8'd7, 2'b01, 8'h07, 1'b0, t);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_ovf_count", 64'(ovf_count), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        sbq.delete();
        n_ovf_sent = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        send(8'd3, 2'b11, 8'hFD, 1'b0, t);
        chk("post_rst_accept", 64'(t), 64'd1);
        idle(4);

        // 65537 illegal-sign beats at full rate: counter saturates.
        t0 = $time;
        for (int i = 0; i < 65537; i++) begin
            send(8'(i), 2'b10, 8'h00, 1'b1, t);
        end
        chk("throughput_cycles", 64'(($time - t0) / 10), 64'd65537);
        idle(4);
        chk("ovf_count_sat", 64'(ovf_count), 64'hFFFF);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hada_sign_compose.md
HADA_SIGN_COMPOSE -- requirements
Module: hada_sign_compose

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width in bits; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  input beat present.
REQ-005 SHALL have port in_ready  output  1  block accepts the input beat this cycle.
REQ-006 SHALL have port in_mag  input  WIDTH  unsigned magnitude.
REQ-007 SHALL have port in_sgn  input  2  signum code: 00 zero, 01 plus, 11 minus, 10 illegal.
REQ-008 SHALL have port out_valid  output  1  result beat present.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result beat.
REQ-010 SHALL have port out_data  output  WIDTH  two's-complement signed result.
REQ-011 SHALL have port out_ovf  output  1  result not representable, or in_sgn illegal.
REQ-012 SHALL have port ovf_count  output  16  count of overflow beats delivered.

Function
REQ-013 SHALL be a two-stage registered pipeline (S1 captures inputs, S2 holds the result), with each stage having its own valid bit.
REQ-014 SHALL transfer an input beat when in_valid && in_ready, and deliver a result beat when out_valid && out_ready.
REQ-015 SHALL drive in_ready = !S1_valid || S1_adv, where S1_adv = !S2_valid || out_ready; out_ready may therefore reach in_ready combinationally.
REQ-016 SHALL have no combinational path from any in_* input to any out_* output.
REQ-017 SHALL have latency of exactly 2 cycles from the input transfer to out_valid when out_ready is held high, and sustain throughput of 1 beat per cycle.
REQ-018 SHALL preserve beat order and never drop or duplicate a beat under any out_ready pattern.
REQ-019 SHALL hold out_data, out_ovf and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL, for sgn=00, output 0 with out_ovf=0, ignoring in_mag.
REQ-021 SHALL, for sgn=01, output +mag and set out_ovf=1 iff mag > 2^(WIDTH-1)-1.
REQ-022 SHALL, for sgn=11, output -mag and set out_ovf=1 iff mag > 2^(WIDTH-1); mag=0 yields 0 with no overflow.
REQ-023 SHALL, for sgn=10, output 0 with out_ovf=1.
REQ-024 SHALL increment ovf_count on each delivered beat with out_ovf=1, saturating at 0xFFFF with no wrap.

Reset
REQ-025 SHALL, while rst is high, asynchronously clear S1_valid, S2_valid, out_valid=0, out_data=0, out_ovf=0 and ovf_count=0.
REQ-026 SHALL drive in_ready=1 during and after reset.
REQ-027 SHALL discard in-flight beats on reset mid-stream, with no beat emerging after reset deasserts.
REQ-028 SHALL accept a beat on the first rising edge of clk after rst deasserts.

Configuration
REQ-029 SHALL use macro HADA_SIGN_COMPOSE_SAT_EN to select overflow handling; out_ovf and ovf_count behave identically in both builds.
REQ-030 SHALL, with HADA_SIGN_COMPOSE_SAT_EN defined, saturate overflowed results: plus to 2^(WIDTH-1)-1, minus to -2^(WIDTH-1).
REQ-031 SHALL, without HADA_SIGN_COMPOSE_SAT_EN, wrap overflowed results to the low WIDTH bits of the exact two's-complement value.

Verification (WIDTH=8)
REQ-032 SHALL cover: mag=5 sgn=11, out_ready=1 -> out_data=0xFB, out_ovf=0, out_valid exactly 2 cycles after the transfer.
REQ-033 SHALL cover: mag=128 sgn=01 -> out_ovf=1; out_data=0x80 without the macro, 0x7F with it; and mag=128 sgn=11 -> 0x80, out_ovf=0.
REQ-034 SHALL cover: mag=200 sgn=11 -> out_ovf=1; out_data=0x38 without the macro, 0x80 with it; ovf_count increments by 1.
REQ-035 SHALL cover: 4 back-to-back beats with out_ready low for 3 cycles -> in_ready=0 after 2 beats are held, all 4 beats delivered in order, outputs stable while stalled.
REQ-036 SHALL cover: rst pulsed with 2 beats in flight -> out_valid=0 immediately and ovf_count=0, no stale beat delivered afterward.
REQ-037 SHALL cover: 65537 sgn=10 beats -> every beat out_data=0 and out_ovf=1; ovf_count ends at 0xFFFF.
